mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a shared 32-word memory.
// Port A is a read-only fetch port; port B does loads/stores with an out-of-range error path.
module mem_arbiter #(
    parameter int unsigned ADDR_W    = 5,
    parameter bit          IDLE_PARK = 1'b0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        a_req,
    input  logic [31:0] a_addr,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic [31:0] a_rdata,

    input  logic        b_req,
    input  logic        b_wen,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [31:0] b_rdata,
    output logic        b_err,

    output logic        m_wen,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    localparam logic [31:0] IDX_MASK = 32'((64'd1 << ADDR_W) - 64'd1);

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_e;

    owner_e      last_gnt_q, last_gnt_d;
    logic        a_rvalid_q, a_rvalid_d;
    logic [31:0] a_rdata_q,  a_rdata_d;
    logic        b_rvalid_q, b_rvalid_d;
    logic [31:0] b_rdata_q,  b_rdata_d;
    logic        b_err_q,    b_err_d;
    logic        b_oor;

    assign b_oor = |(b_addr & ~IDX_MASK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q <= OWNER_B;
            a_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rvalid_q <= 1'b0;
            b_rdata_q  <= '0;
            b_err_q    <= 1'b0;
        end else begin
            last_gnt_q <= last_gnt_d;
            a_rvalid_q <= a_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rvalid_q <= b_rvalid_d;
            b_rdata_q  <= b_rdata_d;
            b_err_q    <= b_err_d;
        end
    end

    // Contention goes to whichever port was not granted last.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!rst) begin
            if (a_req && b_req) begin
                if (last_gnt_q == OWNER_A) begin
                    b_gnt = 1'b1;
                end else begin
                    a_gnt = 1'b1;
                end
            end else begin
                a_gnt = a_req;
                b_gnt = b_req;
            end
        end
    end

    always_comb begin
        m_wen   = b_gnt && b_wen && !b_oor;
        m_wdata = b_wdata;
        if (a_gnt) begin
            m_addr = a_addr & IDX_MASK;
        end else if (b_gnt) begin
            m_addr = b_addr & IDX_MASK;
        end else if (IDLE_PARK) begin
            m_addr = b_addr & IDX_MASK;
        end else begin
            m_addr = a_addr & IDX_MASK;
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (a_gnt) begin
            last_gnt_d = OWNER_A;
        end else if (b_gnt) begin
            last_gnt_d = OWNER_B;
        end

        a_rvalid_d = a_gnt;
        a_rdata_d  = a_gnt ? m_rdata : a_rdata_q;

        // Out-of-range reads still complete, returning zero alongside the error.
        b_rvalid_d = b_gnt && !b_wen;
        b_rdata_d  = b_rdata_q;
        if (b_rvalid_d) begin
            b_rdata_d = b_oor ? '0 : m_rdata;
        end
        b_err_d = b_gnt && b_oor;
    end

    assign a_rvalid = a_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rvalid = b_rvalid_q;
    assign b_rdata  = b_rdata_q;
    assign b_err    = b_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter with a behavioural 32-word memory.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, b_req, b_wen;
    logic [31:0] a_addr, b_addr, b_wdata;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid, b_err, m_wen;
    logic [31:0] a_rdata, b_rdata, m_addr, m_wdata, m_rdata;
    logic        mem_init;
    logic [31:0] mem [32];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(5), .IDLE_PARK(1'b0)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_wen(b_wen), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
        .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    assign m_rdata = (m_addr < 32'd32) ? mem[m_addr[4:0]] : 32'hBAD0BAD0;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'hC0DE0000 + 32'(i);
        end else if (m_wen) begin
            mem[m_addr[4:0]] <= m_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        a_req;
        logic [31:0] a_addr;
        logic        b_req;
        logic        b_wen;
        logic [31:0] b_addr;
        logic [31:0] b_wdata;
        logic        x_a_gnt;
        logic        x_b_gnt;
        logic        x_m_wen;
        logic [31:0] x_m_addr;
        logic        x_a_rvalid;
        logic [31:0] x_a_rdata;
        logic        x_b_rvalid;
        logic [31:0] x_b_rdata;
        logic        x_b_err;
    } vec_t;

    vec_t vecs [13];
    int   a_cnt, b_cnt;

    initial begin
        // inputs | comb: a_gnt b_gnt m_wen m_addr | after edge: a_rv a_rd b_rv b_rd b_err
        vecs[0]  = '{1, 32'h03, 1, 0, 32'h04, 32'h0,        1, 0, 0, 32'h03, 1, 32'hC0DE0003, 0, 32'h0,        0};
        vecs[1]  = '{1, 32'h03, 1, 0, 32'h04, 32'h0,        0, 1, 0, 32'h04, 0, 32'hC0DE0003, 1, 32'hC0DE0004, 0};
        vecs[2]  = '{1, 32'h03, 0, 0, 32'h00, 32'h0,        1, 0, 0, 32'h03, 1, 32'hC0DE0003, 0, 32'hC0DE0004, 0};
        vecs[3]  = '{0, 32'h00, 1, 1, 32'h07, 32'hDEADBEEF, 0, 1, 1, 32'h07, 0, 32'hC0DE0003, 0, 32'hC0DE0004, 0};
        vecs[4]  = '{0, 32'h00, 1, 0, 32'h07, 32'h0,        0, 1, 0, 32'h07, 0, 32'hC0DE0003, 1, 32'hDEADBEEF, 0};
        vecs[5]  = '{0, 32'h00, 1, 0, 32'h20, 32'h0,        0, 1, 0, 32'h00, 0, 32'hC0DE0003, 1, 32'h0,        1};
        vecs[6]  = '{0, 32'h00, 1, 1, 32'h20, 32'h12345678, 0, 1, 0, 32'h00, 0, 32'hC0DE0003, 0, 32'h0,        1};
        vecs[7]  = '{1, 32'h25, 0, 0, 32'h00, 32'h0,        1, 0, 0, 32'h05, 1, 32'hC0DE0005, 0, 32'h0,        0};
        vecs[8]  = '{0, 32'h3E, 0, 0, 32'h09, 32'h0,        0, 0, 0, 32'h1E, 0, 32'hC0DE0005, 0, 32'h0,        0};
        vecs[9]  = '{0, 32'h00, 1, 0, 32'h00, 32'h0,        0, 1, 0, 32'h00, 0, 32'hC0DE0005, 1, 32'hC0DE0000, 0};
        vecs[10] = '{1, 32'h01, 1, 1, 32'h02, 32'h55AA55AA, 1, 0, 0, 32'h01, 1, 32'hC0DE0001, 0, 32'hC0DE0000, 0};
        vecs[11] = '{1, 32'h01, 1, 1, 32'h02, 32'h55AA55AA, 0, 1, 1, 32'h02, 0, 32'hC0DE0001, 0, 32'hC0DE0000, 0};
        vecs[12] = '{1, 32'h02, 0, 0, 32'h00, 32'h0,        1, 0, 0, 32'h02, 1, 32'h55AA55AA, 0, 32'hC0DE0000, 0};

        rst = 1'b1; mem_init = 1'b1;
        a_req = 1'b1; a_addr = 32'h3; b_req = 1'b1; b_wen = 1'b1; b_addr = 32'h1; b_wdata = 32'hFFFFFFFF;
        @(posedge clk); @(posedge clk); #1;
        check("rst_a_gnt",    32'(a_gnt),    32'h0);
        check("rst_b_gnt",    32'(b_gnt),    32'h0);
        check("rst_m_wen",    32'(m_wen),    32'h0);
        check("rst_a_rvalid", 32'(a_rvalid), 32'h0);
        check("rst_b_rvalid", 32'(b_rvalid), 32'h0);
        check("rst_b_err",    32'(b_err),    32'h0);
        check("rst_a_rdata",  a_rdata,       32'h0);
        check("rst_b_rdata",  b_rdata,       32'h0);
        @(negedge clk);
        rst = 1'b0; mem_init = 1'b0; a_req = 1'b0; b_req = 1'b0; b_wen = 1'b0;

        for (int v = 0; v < 13; v++) begin
            @(negedge clk);
            a_req = vecs[v].a_req; a_addr = vecs[v].a_addr;
            b_req = vecs[v].b_req; b_wen = vecs[v].b_wen;
            b_addr = vecs[v].b_addr; b_wdata = vecs[v].b_wdata;
            #1;
            check($sformatf("v%0d_a_gnt", v),  32'(a_gnt), 32'(vecs[v].x_a_gnt));
            check($sformatf("v%0d_b_gnt", v),  32'(b_gnt), 32'(vecs[v].x_b_gnt));
            check($sformatf("v%0d_m_wen", v),  32'(m_wen), 32'(vecs[v].x_m_wen));
            check($sformatf("v%0d_m_addr", v), m_addr,     vecs[v].x_m_addr);
            @(posedge clk); #1;
            check($sformatf("v%0d_a_rvalid", v), 32'(a_rvalid), 32'(vecs[v].x_a_rvalid));
            check($sformatf("v%0d_a_rdata", v),  a_rdata,       vecs[v].x_a_rdata);
            check($sformatf("v%0d_b_rvalid", v), 32'(b_rvalid), 32'(vecs[v].x_b_rvalid));
            check($sformatf("v%0d_b_rdata", v),  b_rdata,       vecs[v].x_b_rdata);
            check($sformatf("v%0d_b_err", v),    32'(b_err),    32'(vecs[v].x_b_err));
        end
        check("mem0_after_oor_write", mem[0], 32'hC0DE0000);

        // Sustained contention: A was granted last, so B leads and they alternate.
        a_cnt = 0; b_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a_req = 1'b1; a_addr = 32'h1; b_req = 1'b1; b_wen = 1'b0; b_addr = 32'h2;
            #1;
            check($sformatf("alt%0d_b_gnt", i), 32'(b_gnt), 32'((i % 2) == 0));
            check($sformatf("alt%0d_a_gnt", i), 32'(a_gnt), 32'((i % 2) == 1));
            if (a_gnt) a_cnt++;
            if (b_gnt) b_cnt++;
            @(posedge clk);
        end
        check("alt_a_count", 32'(a_cnt), 32'd4);
        check("alt_b_count", 32'(b_cnt), 32'd4);

        // Reset right after a read grant drops the pending response and blocks writes.
        @(negedge clk);
        a_req = 1'b1; a_addr = 32'h3; b_req = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_a_rvalid", 32'(a_rvalid), 32'h1);
        @(negedge clk);
        rst = 1'b1; b_req = 1'b1; b_wen = 1'b1; b_addr = 32'h9; b_wdata = 32'h0BADF00D;
        #1;
        check("mid_rst_a_rvalid", 32'(a_rvalid), 32'h0);
        check("mid_rst_a_rdata",  a_rdata,       32'h0);
        check("mid_rst_b_rdata",  b_rdata,       32'h0);
        check("mid_rst_a_gnt",    32'(a_gnt),    32'h0);
        check("mid_rst_b_gnt",    32'(b_gnt),    32'h0);
        check("mid_rst_m_wen",    32'(m_wen),    32'h0);
        @(posedge clk); #1;
        check("rst_edge_a_rvalid", 32'(a_rvalid), 32'h0);
        check("rst_edge_b_err",    32'(b_err),    32'h0);
        check("mem9_unchanged",    mem[9],        32'hC0DE0009);
        @(negedge clk);
        rst = 1'b0; a_req = 1'b1; a_addr = 32'h4; b_req = 1'b1; b_wen = 1'b0; b_addr = 32'h6;
        #1;
        check("post_rst_a_wins", 32'(a_gnt), 32'h1);
        check("post_rst_m_addr", m_addr,     32'h4);
        @(posedge clk); #1;
        check("post_rst_a_rdata", a_rdata, 32'hC0DE0004);
        @(negedge clk);
        #1;
        check("post_rst_b_next", 32'(b_gnt), 32'h1);
        @(posedge clk); #1;
        check("post_rst_b_rdata", b_rdata, 32'hC0DE0006);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
